// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the windowed detection counter:
//   - CNT_W_DEFAULT / WIN_W_DEFAULT : default widths of the count and of the
//     window length input
//   - state_t                       : IDLE / RUN state of the window FSM
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int WIN_W_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// -----------------------------------------------------------------------------
// seq_det_sat_cnt
// Saturating CNT_W-bit event accumulator with a sticky saturation flag.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   clear     : restart from zero next cycle (wins over inc)
//   inc       : one event this cycle
//   total     : accumulated count INCLUDING this cycle's inc (combinational),
//               so the owner can report the window's final event on the same
//               cycle it closes the window
//   total_sat : saturation flag including this cycle's inc (combinational)
// The flag is set when an event arrives while the count is already at its
// maximum, i.e. when an event is actually lost.
// -----------------------------------------------------------------------------
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] total,
    output logic             total_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;
    logic             sat_reg;

    always_comb begin
        total     = count_reg;
        total_sat = sat_reg;
        if (inc) begin
            if (count_reg == CNT_MAX) begin
                total_sat = 1'b1;
            end else begin
                total = count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= total;
            sat_reg   <= total_sat;
        end
    end

endmodule

// File: rtl/seq_det_win_counter.sv
// -----------------------------------------------------------------------------
// seq_det_win_counter
// Counts detector hits over back-to-back windows of win_len cycles and hands
// each window's total to a consumer through a valid/ready report register.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : 1 = windows run, 0 = idle (current window discarded)
//   det_in       : detector output
//   win_len      : window length in cycles (0 behaves as 1), sampled at the
//                  start of every window
//   cnt_o, sat_o : last reported count and its saturation flag
//   cnt_valid    : report pending, held until cnt_ready
//   cnt_ready    : consumer accepts the report
//   lost_o       : sticky, a finished window found the report still pending
// Build option: define SEQ_DET_WIN_EDGE_EN to count only rising edges of
// det_in instead of every high cycle.
// -----------------------------------------------------------------------------
module seq_det_win_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int WIN_W = WIN_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             det_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             lost_o
);

    state_t           state_reg;
    logic [WIN_W-1:0] timer_reg;
    logic [WIN_W-1:0] last_reg;     // latched window length minus one
    logic [CNT_W-1:0] cnt_reg;
    logic             sat_reg;
    logic             valid_reg;
    logic             lost_reg;

    logic [WIN_W-1:0] last_sample;
    logic             running;
    logic             win_end;
    logic             event_hit;
    logic             acc_clear;
    logic             acc_inc;
    logic [CNT_W-1:0] acc_total;
    logic             acc_total_sat;

    // A zero length collapses to a one-cycle window.
    assign last_sample = (win_len == '0) ? '0 : (win_len - WIN_W'(1));

`ifdef SEQ_DET_WIN_EDGE_EN
    logic prev_det_reg;

    // Held at 0 while idle so the first RUN cycle sees a clean history.
    always_ff @(posedge clock) begin
        if (reset || (state_reg == IDLE)) begin
            prev_det_reg <= 1'b0;
        end else begin
            prev_det_reg <= det_in;
        end
    end

    assign event_hit = det_in & ~prev_det_reg;
`else
    assign event_hit = det_in;
`endif

    assign running   = (state_reg == RUN) && enable;
    assign win_end   = running && (timer_reg == last_reg);
    assign acc_inc   = running && event_hit;
    // The window-end event is already folded into acc_total, so clearing on
    // that cycle starts the next window with no dead cycle.
    assign acc_clear = !running || win_end;

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_acc (
        .clock     (clock),
        .reset     (reset),
        .clear     (acc_clear),
        .inc       (acc_inc),
        .total     (acc_total),
        .total_sat (acc_total_sat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            last_reg  <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
            lost_reg  <= 1'b0;
        end else begin
            // Handshake first; a report loaded below on the same cycle
            // overrides this and keeps valid high.
            if (valid_reg && cnt_ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= RUN;
                        timer_reg <= '0;
                        last_reg  <= last_sample;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (win_end) begin
                        timer_reg <= '0;
                        last_reg  <= last_sample;
                        if (valid_reg && !cnt_ready) begin
                            lost_reg <= 1'b1;
                        end else begin
                            cnt_reg   <= acc_total;
                            sat_reg   <= acc_total_sat;
                            valid_reg <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + WIN_W'(1);
                    end
                end
            endcase
        end
    end

    assign cnt_o     = cnt_reg;
    assign sat_o     = sat_reg;
    assign cnt_valid = valid_reg;
    assign lost_o    = lost_reg;

endmodule

// File: tb/tb_seq_det_win_counter.sv
// -----------------------------------------------------------------------------
// tb_seq_det_win_counter
// Self-checking bench for seq_det_win_counter (default widths CNT_W=8,
// WIN_W=16). Honours SEQ_DET_WIN_EDGE_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_seq_det_win_counter;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int CMAX  = 255;
`ifdef SEQ_DET_WIN_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             det_in;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] cnt_o;
    logic             sat_o;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             lost_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_det_win_counter #(
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .det_in    (det_in),
        .win_len   (win_len),
        .cnt_o     (cnt_o),
        .sat_o     (sat_o),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .lost_o    (lost_o)
    );

    // ---------------- reference model: whole-window event totals ------------
    bit m_run   = 0;
    int m_len   = 1;
    int m_pos   = 0;
    int m_events = 0;
    bit m_prev  = 0;
    int m_cnt   = 0;
    bit m_sat   = 0;
    bit m_valid = 0;
    bit m_lost  = 0;

    task automatic model_update();
        bit ev;
        bit hs;
        bit loaded;
        if (reset) begin
            m_run = 0; m_len = 1; m_pos = 0; m_events = 0; m_prev = 0;
            m_cnt = 0; m_sat = 0; m_valid = 0; m_lost = 0;
            return;
        end
        hs = m_valid && cnt_ready;
        loaded = 0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1;
                m_len = (win_len == 0) ? 1 : int'(win_len);
                m_pos = 0; m_events = 0; m_prev = 0;
            end
        end else if (!enable) begin
            m_run = 0;
        end else begin
            ev = EDGE ? (det_in && !m_prev) : det_in;
            m_prev = det_in;
            m_events += int'(ev);
            if (m_pos == m_len - 1) begin
                if (m_valid && !cnt_ready) begin
                    m_lost = 1;
                end else begin
                    m_cnt = (m_events > CMAX) ? CMAX : m_events;
                    m_sat = (m_events > CMAX);
                    m_valid = 1;
                    loaded = 1;
                end
                m_pos = 0; m_events = 0;
                m_len = (win_len == 0) ? 1 : int'(win_len);
            end else begin
                m_pos++;
            end
        end
        if (hs && !loaded) m_valid = 0;
    endtask

    // ---------------- helpers ----------------------------------------------
    function automatic logic [31:0] dut_word();
        return {21'b0, cnt_o, sat_o, cnt_valid, lost_o};
    endfunction

    function automatic logic [31:0] exp_word(input int c, input bit s, input bit v, input bit l);
        logic [7:0] c8;
        c8 = c[7:0];
        return {21'b0, c8, s, v, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance, update model, compare a little later.
    task automatic step(input bit r, input bit e, input bit d, input int wl, input bit rd);
        reset = r; enable = e; det_in = d; win_len = wl[WIN_W-1:0]; cnt_ready = rd;
        @(posedge clock);
        model_update();
        #1;
        chk("model", dut_word(), exp_word(m_cnt, m_sat, m_valid, m_lost));
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        bit r; bit e; bit d; int wl; bit rd;
        int cnt; bit sat; bit valid; bit lost;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit d, input int wl, input bit rd,
                       input int c, input bit s, input bit v, input bit l);
        vec_t x;
        x.r = r; x.e = e; x.d = d; x.wl = wl; x.rd = rd;
        x.cnt = c; x.sat = s; x.valid = v; x.lost = l;
        tbl.push_back(x);
    endtask

    initial begin
        int c1;
        int c2;
        c1 = EDGE ? 2 : 3;
        c2 = EDGE ? 1 : 4;

        // Pattern 1,0,1,1 in a 4-cycle window
        add(1, 0, 0, 4, 1,   0, 0, 0, 0);
        add(0, 1, 0, 4, 1,   0, 0, 0, 0);   // enter RUN
        add(0, 1, 1, 4, 1,   0, 0, 0, 0);
        add(0, 1, 0, 4, 1,   0, 0, 0, 0);
        add(0, 1, 1, 4, 1,   0, 0, 0, 0);
        add(0, 1, 1, 4, 1,  c1, 0, 1, 0);   // window end -> report
        add(0, 1, 0, 4, 1,  c1, 0, 0, 0);   // accepted, valid for one cycle
        // det_in held high for a full 4-cycle window, then reset mid-window
        add(1, 0, 0, 4, 1,   0, 0, 0, 0);
        add(0, 1, 0, 4, 0,   0, 0, 0, 0);
        add(0, 1, 1, 4, 0,   0, 0, 0, 0);
        add(0, 1, 1, 4, 0,   0, 0, 0, 0);
        add(0, 1, 1, 4, 0,   0, 0, 0, 0);
        add(0, 1, 1, 4, 0,  c2, 0, 1, 0);
        add(0, 1, 0, 4, 1,  c2, 0, 0, 0);
        add(0, 1, 1, 4, 1,  c2, 0, 0, 0);
        add(1, 1, 1, 4, 1,   0, 0, 0, 0);   // reset wins over enable/det_in

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].wl, tbl[i].rd);
            chk($sformatf("vec%0d", i), dut_word(),
                exp_word(tbl[i].cnt, tbl[i].sat, tbl[i].valid, tbl[i].lost));
        end

        // ---- held report with drops, then handshake (win_len=2) ----
        step(1, 0, 0, 2, 0);
        step(0, 1, 1, 2, 0);                          // enter
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 2, 0);                          // first report
        for (int i = 0; i < 6; i++) step(0, 1, 1, 2, 0);
        chk("hold_cnt",   {24'b0, cnt_o}, EDGE ? 32'd1 : 32'd2);
        chk("hold_valid", {31'b0, cnt_valid}, 32'd1);
        chk("hold_lost",  {31'b0, lost_o}, 32'd1);
        step(0, 1, 1, 2, 1);                          // pos0 of a window: plain accept
        chk("accept_valid", {31'b0, cnt_valid}, 32'd0);

        // ---- window end coincident with handshake ----
        step(1, 0, 0, 2, 0);
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 2, 0);                          // report pending
        step(0, 1, 0, 2, 0);
        step(0, 1, 1, 2, 1);                          // end + handshake
        chk("coinc_cnt",   {24'b0, cnt_o}, 32'd1);
        chk("coinc_valid", {31'b0, cnt_valid}, 32'd1);
        chk("coinc_lost",  {31'b0, lost_o}, 32'd0);

        // ---- enable dropped mid-window, fresh window afterwards ----
        step(1, 0, 0, 5, 1);
        step(0, 1, 0, 5, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5, 1);
        step(0, 0, 1, 5, 1);
        step(0, 0, 1, 5, 1);                          // idle, det ignored
        step(0, 0, 1, 5, 1);
        chk("abort_valid", {31'b0, cnt_valid}, 32'd0);
        step(0, 1, 0, 5, 1);                          // re-enter
        step(0, 1, 0, 5, 1);
        step(0, 1, 1, 5, 1);
        step(0, 1, 0, 5, 1);
        step(0, 1, 0, 5, 1);
        step(0, 1, 1, 5, 1);
        chk("fresh_cnt",   {24'b0, cnt_o}, 32'd2);
        chk("fresh_valid", {31'b0, cnt_valid}, 32'd1);

        // ---- saturation: 300 hits in a 600-cycle window ----
        step(1, 0, 0, 600, 1);
        step(0, 1, 0, 600, 1);
        for (int i = 0; i < 600; i++) step(0, 1, (i % 2) == 0, 600, 1);
        chk("sat_cnt", {24'b0, cnt_o}, 32'd255);
        chk("sat_flag", {31'b0, sat_o}, 32'd1);

        // ---- win_len 0 acts as a one-cycle window ----
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("len0_cnt",   {24'b0, cnt_o}, 32'd1);
        chk("len0_valid", {31'b0, cnt_valid}, 32'd1);

        // ---- reset with a pending report and a window in progress ----
        step(0, 1, 1, 3, 0);
        step(1, 1, 1, 3, 1);
        chk("rst_all", dut_word(), 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 150) == 0, ($urandom % 16) != 0, $urandom % 2,
                 int'($urandom % 7), ($urandom % 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_win_counter.md
SEQ_DET_WIN_COUNTER -- requirements
Module: seq_det_win_counter

Interface
REQ-001 Parameter CNT_W, default 8: width of the detection count.
REQ-002 Parameter WIN_W, default 16: width of the window length input.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  high = windows run; low = idle, window aborted.
REQ-007 det_in  input  1  detector output, one detection per high cycle.
REQ-008 win_len  input  WIN_W  window length in cycles; sampled at window start.
REQ-009 cnt_o  output  CNT_W  reported count of the last completed window.
REQ-010 sat_o  output  1  reported count saturated during its window.
REQ-011 cnt_valid  output  1  report valid; held until accepted.
REQ-012 cnt_ready  input  1  consumer accepts the report.
REQ-013 lost_o  output  1  sticky: a completed window was dropped.

Function
REQ-014 FSM states SHALL be IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-015 Entering RUN SHALL latch win_len (0 treated as 1), clear the timer and the accumulator.
REQ-016 In RUN, each counted det_in cycle SHALL increment the accumulator, saturating at 2^CNT_W-1 and setting an internal sat flag.
REQ-017 Window end = timer equals latched length-1; the event on that cycle SHALL be included in the report.
REQ-018 At window end, accumulator+event and sat SHALL load cnt_o/sat_o with cnt_valid=1 on the next cycle; the accumulator, sat and timer restart, and win_len is re-latched, with no dead cycle.
REQ-019 The report SHALL be consumed when cnt_valid&&cnt_ready; cnt_valid then falls next cycle; cnt_o/sat_o stay stable while cnt_valid=1.
REQ-020 Window end with cnt_valid=1 and no handshake that cycle SHALL drop the new result and set lost_o.
REQ-021 Window end in the same cycle as a handshake SHALL load the new report; cnt_valid stays 1.
REQ-022 enable falling mid-window SHALL discard the partial window with no report; a pending report remains valid until accepted.
REQ-023 In IDLE, det_in SHALL be ignored.
REQ-024 Latency det_in to report: the window length plus 1 cycle.

Reset
REQ-025 reset SHALL force IDLE, cnt_o=0, sat_o=0, cnt_valid=0, lost_o=0, accumulator/timer/sat=0.
REQ-026 Reset mid-window or with a pending report SHALL discard both; reset has priority over all other inputs.

Configuration
REQ-027 With macro SEQ_DET_WIN_EDGE_EN defined, only rising edges of det_in SHALL count; the previous det_in value is registered, reset to 0 and cleared on entering RUN.
REQ-028 Without SEQ_DET_WIN_EDGE_EN, every high det_in cycle SHALL count.

Structure
REQ-029 Package seq_det_pkg SHALL hold the IDLE/RUN state typedef and the CNT_W/WIN_W defaults.
REQ-030 Sub-module seq_det_sat_cnt (saturating CNT_W counter with clear, increment, sat flag) SHALL implement the accumulator.

Verification
REQ-031 win_len=4, det_in pattern 1,0,1,1, cnt_ready=1 -> one report cnt_o=3, sat_o=0, cnt_valid high 1 cycle.
REQ-032 CNT_W=2, win_len=8, det_in=1 constantly -> cnt_o=3, sat_o=1.
REQ-033 win_len=2, cnt_ready=0 for 6 cycles -> first report held unchanged, lost_o=1; then cnt_ready=1 -> handshake, cnt_valid=0.
REQ-034 Window end coincident with handshake -> new count loaded, cnt_valid stays 1, lost_o=0.
REQ-035 enable dropped after 3 of 5 window cycles with det_in=1 -> no report; re-enable starts a fresh window from 0.
REQ-036 det_in held high for 4 cycles, win_len=4 -> cnt_o=1 with SEQ_DET_WIN_EDGE_EN, cnt_o=4 without; reset mid-window -> all outputs 0 next cycle.
